// File: rtl/instr_fetch_buffer_if.sv
// Handshake and memory bus between the PC-update stage, instruction memory,
// decode and the instruction fetch buffer.

interface instr_fetch_buffer_if;
    logic        pc_valid;
    logic [31:0] pc;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misaligned;
    logic        if_ready;

    modport master (
        output pc_valid, pc, flush, imem_rdata, if_ready,
        input  pc_ready, imem_req, imem_addr, if_valid, if_pc, if_instr, if_misaligned
    );

    modport slave (
        input  pc_valid, pc, flush, imem_rdata, if_ready,
        output pc_ready, imem_req, imem_addr, if_valid, if_pc, if_instr, if_misaligned
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues fixed-latency imem reads for accepted PCs and
// queues {pc, instr, misaligned} for decode; a flush drops buffered and in-flight fetches.

module instr_fetch_buffer_chk #(
    parameter int DEPTH = 4
) (
    input logic                     clk,
    input logic                     rst,
    input logic                     push_s,
    input logic                     pop_s,
    input logic [$clog2(DEPTH):0]   occ_r,
    input logic [$clog2(DEPTH):0]   inflight_r
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    no_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push_s && !pop_s && ({1'b0, occ_r} == DEPTH_C)));

    credit_bound_a: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, occ_r} + {1'b0, inflight_r}) <= DEPTH_C));
endmodule

module instr_fetch_buffer #(
    parameter int DEPTH       = 4,
    parameter int MEM_LATENCY = 1
) (
    input logic                  clk,
    input logic                  rst,
    instr_fetch_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [31:0]            fifo_pc_r    [DEPTH];
    logic [31:0]            fifo_instr_r [DEPTH];
    logic [DEPTH-1:0]       fifo_mis_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [CNT_W-1:0]       occ_r;
    logic [CNT_W-1:0]       inflight_r;
    logic [31:0]            pipe_pc_r    [MEM_LATENCY];
    logic [MEM_LATENCY-1:0] pipe_mis_r;
    logic [MEM_LATENCY-1:0] pipe_live_r;

    logic                   credit_s;
    logic                   pc_ready_s;
    logic                   accept_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   if_valid_s;
    logic [CNT_W-1:0]       occ_nxt_s;
    logic [CNT_W-1:0]       inflight_nxt_s;

    // A credit covers both buffered and in-flight fetches; a pop only frees it next cycle.
    assign credit_s   = ({1'b0, occ_r} + {1'b0, inflight_r}) < DEPTH_C;
    assign pc_ready_s = !rst && !bus.flush && credit_s;
    assign accept_s   = bus.pc_valid && pc_ready_s;
    assign push_s     = pipe_live_r[MEM_LATENCY-1] && !bus.flush;
    assign if_valid_s = (occ_r != {CNT_W{1'b0}});
    assign pop_s      = if_valid_s && bus.if_ready && !bus.flush;

    // Next occupancy and in-flight counts; a flush zeroes both.
    always_comb begin
        occ_nxt_s      = occ_r;
        inflight_nxt_s = inflight_r;
        if (bus.flush) begin
            occ_nxt_s      = {CNT_W{1'b0}};
            inflight_nxt_s = {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   occ_nxt_s = occ_r + CNT_ONE;
                2'b01:   occ_nxt_s = occ_r - CNT_ONE;
                default: occ_nxt_s = occ_r;
            endcase
            case ({accept_s, pipe_live_r[MEM_LATENCY-1]})
                2'b10:   inflight_nxt_s = inflight_r + CNT_ONE;
                2'b01:   inflight_nxt_s = inflight_r - CNT_ONE;
                default: inflight_nxt_s = inflight_r;
            endcase
        end
    end

    // FIFO pointers and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            occ_r      <= {CNT_W{1'b0}};
            inflight_r <= {CNT_W{1'b0}};
        end else begin
            occ_r      <= occ_nxt_s;
            inflight_r <= inflight_nxt_s;
            if (bus.flush) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Latency pipe: stage 0 takes the accepted PC, the tail lines up with imem_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_live_r <= {MEM_LATENCY{1'b0}};
            pipe_mis_r  <= {MEM_LATENCY{1'b0}};
            for (int i = 0; i < MEM_LATENCY; i++) pipe_pc_r[i] <= 32'h0000_0000;
        end else begin
            pipe_live_r[0] <= accept_s;
            pipe_pc_r[0]   <= bus.pc;
            pipe_mis_r[0]  <= (bus.pc[1:0] != 2'b00);
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_live_r[i] <= pipe_live_r[i-1] && !bus.flush;
                pipe_pc_r[i]   <= pipe_pc_r[i-1];
                pipe_mis_r[i]  <= pipe_mis_r[i-1];
            end
        end
    end

    // FIFO storage, written from the pipe tail together with the returning word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mis_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i]    <= 32'h0000_0000;
                fifo_instr_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_pc_r[wr_ptr_r]    <= pipe_pc_r[MEM_LATENCY-1];
            fifo_instr_r[wr_ptr_r] <= bus.imem_rdata;
            fifo_mis_r[wr_ptr_r]   <= pipe_mis_r[MEM_LATENCY-1];
        end
    end

    assign bus.pc_ready      = pc_ready_s;
    assign bus.imem_req      = accept_s;
    assign bus.imem_addr     = {bus.pc[31:2], 2'b00};
    assign bus.if_valid      = if_valid_s;
    assign bus.if_pc         = fifo_pc_r[rd_ptr_r];
    assign bus.if_instr      = fifo_instr_r[rd_ptr_r];
    assign bus.if_misaligned = fifo_mis_r[rd_ptr_r];

    instr_fetch_buffer_chk #(.DEPTH(DEPTH)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .push_s     (push_s),
        .pop_s      (pop_s),
        .occ_r      (occ_r),
        .inflight_r (inflight_r)
    );
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: a DEPTH=4/latency-1 and a DEPTH=8/latency-3 instance
// share stimulus and are each compared every cycle against an in-order delivery model.

module tb_instr_fetch_buffer;
    logic        clk;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc;
    logic        flush;
    logic        if_ready;

    int n_vec;
    int n_err;
    int now;

    instr_fetch_buffer_if b1 ();
    instr_fetch_buffer_if b3 ();

    instr_fetch_buffer #(.DEPTH(4), .MEM_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    instr_fetch_buffer #(.DEPTH(8), .MEM_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

    assign b1.pc_valid = pc_valid;
    assign b1.pc       = pc;
    assign b1.flush    = flush;
    assign b1.if_ready = if_ready;
    assign b3.pc_valid = pc_valid;
    assign b3.pc       = pc;
    assign b3.flush    = flush;
    assign b3.if_ready = if_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Instruction memory: answers exactly latency cycles after a request, junk otherwise.
    logic        m1_v;
    logic [31:0] m1_a;
    logic [2:0]  m3_v;
    logic [31:0] m3_a [3];
    logic [31:0] junk;
    always @(posedge clk) begin
        m1_v    <= b1.imem_req;
        m1_a    <= b1.imem_addr;
        m3_v    <= {m3_v[1:0], b3.imem_req};
        m3_a[0] <= b3.imem_addr;
        m3_a[1] <= m3_a[0];
        m3_a[2] <= m3_a[1];
        junk    <= $urandom;
    end
    assign b1.imem_rdata = (m1_v === 1'b1)    ? imem_word(m1_a)    : junk;
    assign b3.imem_rdata = (m3_v[2] === 1'b1) ? imem_word(m3_a[2]) : junk;

    // Reference model: accepted PCs in order, each deliverable from accept+latency+1.
    logic [31:0] ent_pc  [2][16];
    int          ent_rdy [2][16];
    int          hd [2];
    int          tl [2];

    logic        obs_valid [2];
    logic        obs_ready [2];
    logic        obs_req   [2];
    logic        obs_mis   [2];
    logic [31:0] obs_pc    [2];
    logic [31:0] obs_ins   [2];
    logic [31:0] obs_addr  [2];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_cycle(input int d);
        logic v, r, rq, mis;
        logic [31:0] ipc, ins, ad, hpc;
        int cnt, dp, lt;
        logic e_rdy, e_val, acc, pop;
        if (d == 0) begin
            v = b1.if_valid; r = b1.pc_ready; rq = b1.imem_req; mis = b1.if_misaligned;
            ipc = b1.if_pc; ins = b1.if_instr; ad = b1.imem_addr; dp = 4; lt = 1;
        end else begin
            v = b3.if_valid; r = b3.pc_ready; rq = b3.imem_req; mis = b3.if_misaligned;
            ipc = b3.if_pc; ins = b3.if_instr; ad = b3.imem_addr; dp = 8; lt = 3;
        end
        cnt   = tl[d] - hd[d];
        e_rdy = !rst && !flush && (cnt < dp);
        e_val = !rst && (cnt > 0) && (ent_rdy[d][hd[d] % 16] <= now);
        acc   = pc_valid && e_rdy;
        chk1($sformatf("pc_ready[%0d] t=%0d", d, now), r, e_rdy);
        chk1($sformatf("if_valid[%0d] t=%0d", d, now), v, e_val);
        chk1($sformatf("imem_req[%0d] t=%0d", d, now), rq, acc);
        if (acc) chk32($sformatf("imem_addr[%0d] t=%0d", d, now), ad, {pc[31:2], 2'b00});
        if (e_val) begin
            hpc = ent_pc[d][hd[d] % 16];
            chk32($sformatf("if_pc[%0d] t=%0d", d, now), ipc, hpc);
            chk32($sformatf("if_instr[%0d] t=%0d", d, now), ins, imem_word({hpc[31:2], 2'b00}));
            chk1($sformatf("if_misaligned[%0d] t=%0d", d, now), mis, hpc[1:0] != 2'b00);
        end
        obs_valid[d] = v; obs_ready[d] = r; obs_req[d] = rq; obs_mis[d] = mis;
        obs_pc[d] = ipc; obs_ins[d] = ins; obs_addr[d] = ad;
        pop = e_val && if_ready && !flush;
        if (rst || flush) begin
            hd[d] = tl[d];
        end else begin
            if (pop) hd[d] = hd[d] + 1;
            if (acc) begin
                ent_pc[d][tl[d] % 16]  = pc;
                ent_rdy[d][tl[d] % 16] = now + lt + 1;
                tl[d] = tl[d] + 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle(0);
        model_cycle(1);
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic wait_first(output logic [31:0] f0, output logic [31:0] f1);
        logic g0, g1;
        g0 = 1'b0; g1 = 1'b0; f0 = 32'hFFFF_FFFF; f1 = 32'hFFFF_FFFF;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (!g0 && obs_valid[0] === 1'b1) begin g0 = 1'b1; f0 = obs_pc[0]; end
            if (!g1 && obs_valid[1] === 1'b1) begin g1 = 1'b1; f1 = obs_pc[1]; end
        end
    endtask

    initial begin
        logic [31:0] f0, f1;
        int acc_cnt [2];
        rst = 1'b1; pc_valid = 1'b0; pc = 32'h0; flush = 1'b0; if_ready = 1'b0;
        n_vec = 0; n_err = 0; now = 0;
        for (int d = 0; d < 2; d++) begin
            hd[d] = 0; tl[d] = 0;
            for (int k = 0; k < 16; k++) begin ent_pc[d][k] = 32'h0; ent_rdy[d][k] = 0; end
        end
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            chk1("rst_if_valid", obs_valid[d], 1'b0);
            chk1("rst_pc_ready", obs_ready[d], 1'b0);
            chk1("rst_imem_req", obs_req[d], 1'b0);
            chk32("rst_if_pc", obs_pc[d], 32'h0);
            chk32("rst_if_instr", obs_ins[d], 32'h0);
            chk1("rst_if_mis", obs_mis[d], 1'b0);
        end
        rst = 1'b0;

        // Back-to-back after reset release, latency 1.
        pc_valid = 1'b1; pc = 32'h0; if_ready = 1'b1; tick();
        chk1("s1_c0_valid", obs_valid[0], 1'b0);
        pc = 32'h4; tick();
        chk1("s1_c1_valid", obs_valid[0], 1'b0);
        pc = 32'h8; tick();
        chk1("s1_c2_valid", obs_valid[0], 1'b1);
        chk32("s1_c2_pc", obs_pc[0], 32'h0);
        pc_valid = 1'b0; tick();
        chk32("s1_c3_pc", obs_pc[0], 32'h4);
        tick();
        chk32("s1_c4_pc", obs_pc[0], 32'h8);
        chk32("s1_c4_instr", obs_ins[0], imem_word(32'h8));
        tick();
        chk1("s1_c5_valid", obs_valid[0], 1'b0);
        repeat (6) tick();

        // Backpressure: six PCs offered with decode stalled.
        if_ready = 1'b0; acc_cnt[0] = 0; acc_cnt[1] = 0;
        for (int i = 0; i < 6; i++) begin
            pc_valid = 1'b1; pc = 32'h200 + 32'(i * 4); tick();
            for (int d = 0; d < 2; d++) acc_cnt[d] += (obs_ready[d] === 1'b1) ? 1 : 0;
        end
        chk32("bp_accepted_d4", 32'(acc_cnt[0]), 32'd4);
        chk32("bp_accepted_d8", 32'(acc_cnt[1]), 32'd6);
        pc_valid = 1'b0; repeat (5) tick();
        chk1("bp_stalled_ready", obs_ready[0], 1'b0);
        chk32("bp_head_pc", obs_pc[0], 32'h200);
        if_ready = 1'b1; tick();
        chk1("bp_pop_cycle_ready", obs_ready[0], 1'b0);
        tick();
        chk1("bp_after_pop_ready", obs_ready[0], 1'b1);
        chk32("bp_second_pc", obs_pc[0], 32'h204);
        repeat (8) tick();

        // Flush with two buffered and one in flight.
        if_ready = 1'b0;
        pc_valid = 1'b1; pc = 32'h300; tick();
        pc = 32'h304; tick();
        pc_valid = 1'b0; tick(); tick();
        pc_valid = 1'b1; pc = 32'h308; tick();
        pc_valid = 1'b0; flush = 1'b1; if_ready = 1'b1; tick();
        chk1("fl_F_ready_d4", obs_ready[0], 1'b0);
        chk1("fl_F_ready_d8", obs_ready[1], 1'b0);
        chk1("fl_F_valid_d4", obs_valid[0], 1'b1);
        flush = 1'b0; pc_valid = 1'b1; pc = 32'h100; tick();
        chk1("fl_F1_valid_d4", obs_valid[0], 1'b0);
        chk1("fl_F1_valid_d8", obs_valid[1], 1'b0);
        chk1("fl_F1_ready_d4", obs_ready[0], 1'b1);
        chk1("fl_F1_ready_d8", obs_ready[1], 1'b1);
        pc_valid = 1'b0;
        wait_first(f0, f1);
        chk32("fl_first_pc_d4", f0, 32'h100);
        chk32("fl_first_pc_d8", f1, 32'h100);
        repeat (4) tick();

        // Streaming on the latency-3 instance: one instruction per cycle after startup.
        if_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pc_valid = 1'b1; pc = 32'h400 + 32'(i * 4); tick();
            chk1("st_ready_d8", obs_ready[1], 1'b1);
            if (i >= 4) begin
                chk1("st_valid_d8", obs_valid[1], 1'b1);
                chk32("st_pc_d8", obs_pc[1], 32'h400 + 32'((i - 4) * 4));
            end
        end
        pc_valid = 1'b0; repeat (8) tick();

        // Misaligned PC.
        pc_valid = 1'b1; pc = 32'h6; tick();
        chk1("mis_req", obs_req[0], 1'b1);
        chk32("mis_addr", obs_addr[0], 32'h4);
        pc_valid = 1'b0; tick(); tick();
        chk1("mis_valid", obs_valid[0], 1'b1);
        chk32("mis_pc", obs_pc[0], 32'h6);
        chk1("mis_flag", obs_mis[0], 1'b1);
        chk32("mis_instr", obs_ins[0], imem_word(32'h4));
        repeat (6) tick();

        // Asynchronous reset in the middle of a stream.
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin pc_valid = 1'b1; pc = 32'h500 + 32'(i * 4); tick(); end
        #2 rst = 1'b1;
        #1;
        chk1("arst_valid_d4", b1.if_valid, 1'b0);
        chk1("arst_ready_d4", b1.pc_ready, 1'b0);
        chk1("arst_valid_d8", b3.if_valid, 1'b0);
        chk1("arst_ready_d8", b3.pc_ready, 1'b0);
        tick(); tick();
        rst = 1'b0; pc_valid = 1'b0; if_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("arst_no_stale_d4", obs_valid[0], 1'b0);
            chk1("arst_no_stale_d8", obs_valid[1], 1'b0);
        end
        pc_valid = 1'b1; pc = 32'h800; tick();
        pc_valid = 1'b0;
        wait_first(f0, f1);
        chk32("arst_first_pc_d4", f0, 32'h800);
        chk32("arst_first_pc_d8", f1, 32'h800);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            pc_valid = ($urandom_range(0, 9) < 7);
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            if_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0; pc_valid = 1'b0; if_ready = 1'b1;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
